// File: rtl/breakout_pkg.sv
// Shared definitions for the Breakout game controller: state codes and
// default round timing.
package breakout_pkg;

  // State codes are also shown on the board LEDs, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StOver  = 3'd4,
    StWin   = 3'd5,
    StPause = 3'd6
  } game_state_e;

  localparam int unsigned LivesDefault      = 3;
  localparam int unsigned ServeTicksDefault = 60;
  localparam int unsigned MissTicksDefault  = 90;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registers an active-low push button and flags a one-cycle event on its
// falling edge (release -> press).
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  logic btn_q;
  logic armed_q;

  // btn_q idles at the released level; armed_q masks the first cycle after
  // reset so a button held through reset never looks like a fresh press.
  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_q   <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn;
      armed_q <= 1'b1;
    end
  end

  // Falling edge of the active-low button.
  always_comb begin
    evt = armed_q & btn_q & ~btn;
  end

endmodule

// File: rtl/game_sequencer.sv
// Breakout round sequencer: idle / serve / play / miss / over / win, with
// lives and saturating score. Gates the paddle and ball datapaths.
// Optional pause state is built only when GAME_PAUSE_EN is defined.
module game_sequencer
  import breakout_pkg::*;
#(
  parameter int unsigned LIVES       = LivesDefault,
  parameter int unsigned SERVE_TICKS = ServeTicksDefault,
  parameter int unsigned MISS_TICKS  = MissTicksDefault,
  parameter int unsigned SCORE_W     = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               tick,
  input  logic               ball_lost,
  input  logic               brick_hit,
  input  logic               all_cleared,
  output logic               bar_en,
  output logic               ball_en,
  output logic               ball_load,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state
);

  localparam int unsigned MaxTicks = max_u(SERVE_TICKS, MISS_TICKS);
  localparam int unsigned CntW     = (MaxTicks > 0) ? $clog2(MaxTicks + 1) : 1;

  localparam logic [CntW-1:0]    ServeLoad = CntW'(SERVE_TICKS);
  localparam logic [CntW-1:0]    MissLoad  = CntW'(MISS_TICKS);
  localparam logic [CntW-1:0]    CntOne    = CntW'(1);
  localparam logic [1:0]         LivesInit = 2'(LIVES);
  localparam logic [SCORE_W-1:0] ScoreMax  = '1;
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);

  game_state_e        state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic start_evt;
  logic pause_evt;

  btn_edge u_start_edge (
    .clock (clock),
    .reset (reset),
    .btn   (start),
    .evt   (start_evt)
  );

`ifdef GAME_PAUSE_EN
  btn_edge u_pause_edge (
    .clock (clock),
    .reset (reset),
    .btn   (pause),
    .evt   (pause_evt)
  );
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_evt    = 1'b0;
`endif

  // Round state, lives, score and wait counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      lives_q <= LivesInit;
      score_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: round sequencing, life/score bookkeeping, tick countdown.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle, StOver, StWin: begin
        if (start_evt) begin
          lives_d = LivesInit;
          score_d = '0;
          cnt_d   = ServeLoad;
          state_d = StServe;
        end
      end

      // A tick at terminal count is consumed by the exit itself.
      StServe: begin
        if (tick) begin
          if (cnt_q == '0) begin
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end

      StPlay: begin
        // Scoring happens even on the cycle a transition is taken.
        if (brick_hit && (score_q != ScoreMax)) begin
          score_d = score_q + ScoreOne;
        end
        if (all_cleared) begin
          state_d = StWin;
        end else if (ball_lost) begin
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          if (lives_q <= 2'd1) begin
            state_d = StOver;
          end else begin
            cnt_d   = MissLoad;
            state_d = StMiss;
          end
        end else if (pause_evt) begin
          state_d = StPause;
        end
      end

      StMiss: begin
        if (tick) begin
          if (cnt_q == '0) begin
            cnt_d   = ServeLoad;
            state_d = StServe;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end

`ifdef GAME_PAUSE_EN
      // Game inputs are ignored and score/lives hold while paused.
      StPause: begin
        if (pause_evt) begin
          state_d = StPlay;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Enables decode directly from the current state.
  always_comb begin
    bar_en    = (state_q == StServe) || (state_q == StPlay);
    ball_en   = (state_q == StPlay);
    ball_load = (state_q == StServe);
    lives     = lives_q;
    score     = score_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short serve/miss waits and a 3-bit
// score. Expected outputs are queued with each step and checked after the edge.
module tb_game_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       pause;
  logic       tick;
  logic       ball_lost;
  logic       brick_hit;
  logic       all_cleared;
  logic       bar_en;
  logic       ball_en;
  logic       ball_load;
  logic [1:0] lives;
  logic [2:0] score;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [1:0] lv;
    logic [2:0] sc;
    logic       bar;
    logic       ball;
    logic       load;
  } exp_t;

  exp_t exp_q[$];

  game_sequencer #(
    .LIVES       (3),
    .SERVE_TICKS (2),
    .MISS_TICKS  (3),
    .SCORE_W     (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .tick        (tick),
    .ball_lost   (ball_lost),
    .brick_hit   (brick_hit),
    .all_cleared (all_cleared),
    .bar_en      (bar_en),
    .ball_en     (ball_en),
    .ball_load   (ball_load),
    .lives       (lives),
    .score       (score),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drain();
    exp_t e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (state === e.st) else begin
        errors++;
        $error("FAIL %s state got %0d want %0d", e.tag, state, e.st);
      end
      checks++;
      assert (lives === e.lv) else begin
        errors++;
        $error("FAIL %s lives got %0d want %0d", e.tag, lives, e.lv);
      end
      checks++;
      assert (score === e.sc) else begin
        errors++;
        $error("FAIL %s score got %0d want %0d", e.tag, score, e.sc);
      end
      checks++;
      assert (bar_en === e.bar) else begin
        errors++;
        $error("FAIL %s bar_en got %0b want %0b", e.tag, bar_en, e.bar);
      end
      checks++;
      assert (ball_en === e.ball) else begin
        errors++;
        $error("FAIL %s ball_en got %0b want %0b", e.tag, ball_en, e.ball);
      end
      checks++;
      assert (ball_load === e.load) else begin
        errors++;
        $error("FAIL %s ball_load got %0b want %0b", e.tag, ball_load, e.load);
      end
    end
  endtask

  // Queue the expected post-edge outputs, clock once, drop pulses, compare.
  task automatic step(input string tag, input int st, input int lv, input int sc);
    exp_t e;
    e.tag  = tag;
    e.st   = 3'(st);
    e.lv   = 2'(lv);
    e.sc   = 3'(sc);
    e.bar  = (st == 1) || (st == 2);
    e.ball = (st == 2);
    e.load = (st == 1);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    tick        = 1'b0;
    ball_lost   = 1'b0;
    brick_hit   = 1'b0;
    all_cleared = 1'b0;
    drain();
  endtask

  // SERVE_TICKS=2: two ticks stay in SERVE, the third enters PLAY.
  task automatic serve_to_play(input int lv, input int sc);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      step("serve_count", 1, lv, sc);
    end
    tick = 1'b1;
    step("serve_exit", 2, lv, sc);
  endtask

  // MISS_TICKS=3: three ticks stay in MISS, the fourth serves again.
  task automatic miss_to_serve(input int lv, input int sc);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step("miss_count", 3, lv, sc);
    end
    tick = 1'b1;
    step("miss_exit", 1, lv, sc);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    pause       = 1'b1;
    tick        = 1'b0;
    ball_lost   = 1'b0;
    brick_hit   = 1'b0;
    all_cleared = 1'b0;
    #1;

    // Reset with start held low throughout.
    step("in_reset", 0, 3, 0);
    step("in_reset2", 0, 3, 0);
    reset = 1'b1;
    step("held_start_release", 0, 3, 0);
    step("held_start_hold", 0, 3, 0);
    start = 1'b1;
    step("idle_btn_up", 0, 3, 0);

    // Start and serve.
    start = 1'b0;
    step("start_evt", 1, 3, 0);
    start = 1'b1;
    step("serve_no_tick", 1, 3, 0);
    serve_to_play(3, 0);
    step("play_idle", 2, 3, 0);

    // Hit and loss together: both act on the same edge.
    brick_hit = 1'b1;
    ball_lost = 1'b1;
    step("hit_and_lost", 3, 2, 1);
    brick_hit = 1'b1;
    step("miss_ignores_hit", 3, 2, 1);
    miss_to_serve(2, 1);
    serve_to_play(2, 1);

    // Eight more hits saturate the 3-bit score at 7.
    for (int i = 1; i <= 8; i++) begin
      brick_hit = 1'b1;
      step("score_sat", 2, 2, (1 + i > 7) ? 7 : 1 + i);
    end

    ball_lost = 1'b1;
    step("lost_second", 3, 1, 7);
    miss_to_serve(1, 7);
    serve_to_play(1, 7);
    ball_lost = 1'b1;
    step("lost_last", 4, 0, 7);
    step("over_hold", 4, 0, 7);

    // Restart from OVER; start is ignored while serving.
    start = 1'b0;
    step("restart_over", 1, 3, 0);
    start = 1'b1;
    step("serve_btn_up", 1, 3, 0);
    start = 1'b0;
    step("start_ignored_serve", 1, 3, 0);
    start = 1'b1;
    serve_to_play(3, 0);

    // all_cleared beats ball_lost; the coincident hit still scores.
    all_cleared = 1'b1;
    ball_lost   = 1'b1;
    brick_hit   = 1'b1;
    step("win_priority", 5, 3, 1);
    step("win_hold", 5, 3, 1);
    start = 1'b0;
    step("restart_win", 1, 3, 0);
    start = 1'b1;
    serve_to_play(3, 0);

`ifdef GAME_PAUSE_EN
    pause = 1'b0;
    step("pause_enter", 6, 3, 0);
    pause     = 1'b1;
    brick_hit = 1'b1;
    ball_lost = 1'b1;
    step("pause_ignores", 6, 3, 0);
    start = 1'b0;
    step("pause_start_ignored", 6, 3, 0);
    start = 1'b1;
    pause = 1'b0;
    step("pause_exit", 2, 3, 0);
    pause = 1'b1;
`else
    pause = 1'b0;
    step("pause_ignored", 2, 3, 0);
    pause = 1'b1;
`endif
    step("play_again", 2, 3, 0);

    // Reset mid-game.
    brick_hit = 1'b1;
    reset     = 1'b0;
    step("mid_reset", 0, 3, 0);
    reset = 1'b1;
    step("after_reset", 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
